// File: rtl/rob_recovery_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rob_recovery_ctrl : sequences flush, RAT restore, writeback drain and fetch
//                     redirect after a retired mispredict or external flush.
// Rev 1.0
// ---------------------------------------------------------------------------
module rob_recovery_ctrl #(
   parameter int NUM_ARCH_REGS = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16,
   parameter int AREG_W        = (NUM_ARCH_REGS > 1) ? $clog2(NUM_ARCH_REGS) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Retire1_Mispred,
   input  logic [15:0]       Retire1_PC,
   input  logic              Retire2_Mispred,
   input  logic [15:0]       Retire2_PC,
   input  logic              Ext_Flush,
   input  logic [15:0]       Ext_PC,
   input  logic              Redirect_Ack,
   output logic              Global_Flush,
   output logic              Dispatch_Stall,
   output logic              Kill_Retire2,
   output logic              RAT_Restore_V,
   output logic [AREG_W-1:0] RAT_Restore_Idx,
   output logic              FreeList_Reset,
   output logic              Redirect_V,
   output logic [15:0]       Redirect_PC,
   output logic [CNT_W-1:0]  Recovery_Count
);

   localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [AREG_W-1:0] LAST_IDX    = AREG_W'(NUM_ARCH_REGS - 1);
   localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FLUSH    = 3'd1,
      RESTORE  = 3'd2,
      SETTLE   = 3'd3,
      REDIRECT = 3'd4
   } state_t;

   state_t           state;
   logic [15:0]      target_pc;
   logic [SET_W-1:0] cnt;
   logic             trigger;
   logic [15:0]      trigger_pc;

   assign trigger = Retire1_Mispred | Retire2_Mispred | Ext_Flush;

   // Older retire slot wins, then the younger one, then the external request.
   always_comb begin
      trigger_pc = Ext_PC;
      if (Retire1_Mispred)
         trigger_pc = Retire1_PC;
      else if (Retire2_Mispred)
         trigger_pc = Retire2_PC;
   end

   assign Kill_Retire2   = (state == IDLE) & Retire1_Mispred;
   assign Dispatch_Stall = (state != IDLE) | trigger;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state           <= IDLE;
         target_pc       <= '0;
         cnt             <= '0;
         Global_Flush    <= 1'b0;
         RAT_Restore_V   <= 1'b0;
         RAT_Restore_Idx <= '0;
         FreeList_Reset  <= 1'b0;
         Redirect_V      <= 1'b0;
         Redirect_PC     <= '0;
         Recovery_Count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  state        <= FLUSH;
                  Global_Flush <= 1'b1;
                  target_pc    <= trigger_pc;
                  if (Recovery_Count != CNT_MAX)
                     Recovery_Count <= Recovery_Count + CNT_W'(1);
               end
            end
            FLUSH: begin
               state           <= RESTORE;
               Global_Flush    <= 1'b0;
               RAT_Restore_V   <= 1'b1;
               RAT_Restore_Idx <= '0;
               FreeList_Reset  <= (LAST_IDX == '0);
            end
            RESTORE: begin
               if (RAT_Restore_Idx == LAST_IDX) begin
                  state           <= SETTLE;
                  RAT_Restore_V   <= 1'b0;
                  RAT_Restore_Idx <= '0;
                  FreeList_Reset  <= 1'b0;
                  cnt             <= SETTLE_INIT;
               end else begin
                  // Free lists rebuild alongside the final register restore.
                  RAT_Restore_Idx <= RAT_Restore_Idx + AREG_W'(1);
                  FreeList_Reset  <= ((RAT_Restore_Idx + AREG_W'(1)) == LAST_IDX);
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state       <= REDIRECT;
                  Redirect_V  <= 1'b1;
                  Redirect_PC <= target_pc;
               end else begin
                  cnt <= cnt - SET_W'(1);
               end
            end
            REDIRECT: begin
               if (Redirect_Ack) begin
                  state       <= IDLE;
                  Redirect_V  <= 1'b0;
                  Redirect_PC <= '0;
                  cnt         <= '0;
               end
            end
            default: begin
               state           <= IDLE;
               Global_Flush    <= 1'b0;
               RAT_Restore_V   <= 1'b0;
               RAT_Restore_Idx <= '0;
               FreeList_Reset  <= 1'b0;
               Redirect_V      <= 1'b0;
               Redirect_PC     <= '0;
               cnt             <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
